// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } dmem_state_e;

    localparam int M_READ_BIT  = 1;
    localparam int M_WRITE_BIT = 0;

    localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/dmem_perf_cnt.sv
// Saturating stall-cycle counter; cleared only by reset.
module dmem_perf_cnt
    import dmem_ctrl_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   inc_i,
    output logic [STALL_CNT_W-1:0] cnt_o
);

    logic [STALL_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + STALL_CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences EX/MEM data-memory accesses over a req/ack handshake and stalls the pipeline meanwhile.
// Optional stall counter port stall_cnt_o is built when DMEM_CTRL_PERF_EN is defined.
//
//   state  | meaning
//   IDLE   | no access outstanding; a non-zero M_i stalls and latches the request
//   ACCESS | request asserted to memory, waiting for ack
//   DONE   | access complete, pipeline advances; M_i is not re-examined
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [1:0]    M_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          stall_o
`ifdef DMEM_CTRL_PERF_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);

    dmem_state_e state_q, state_d;
    logic        mem_op;
    logic        capture_en;

    // 2'b11 is illegal; taking we from the write bit alone turns it into a store.
    assign mem_op = M_i[M_READ_BIT] | M_i[M_WRITE_BIT];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            mem_req_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_req_o <= (state_d == ACCESS);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_op) state_d = ACCESS;
            ACCESS:  if (mem_ack_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o    = 1'b0;
        capture_en = 1'b0;
        case (state_q)
            IDLE: begin
                stall_o    = mem_op;
                capture_en = mem_op;
            end
            ACCESS:  stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_o     <= '0;
        end else begin
            if (capture_en) begin
                mem_we_o    <= M_i[M_WRITE_BIT];
                mem_addr_o  <= addr_i;
                mem_wdata_o <= wdata_i;
            end
            if ((state_q == ACCESS) && mem_ack_i && !mem_we_o) begin
                rdata_o <= mem_rdata_i;
            end
        end
    end

`ifdef DMEM_CTRL_PERF_EN
    dmem_perf_cnt u_perf_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (stall_o),
        .cnt_o   (stall_cnt_o)
    );
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl with an expected-access scoreboard.
module tb_dmem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [1:0]  M_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] rdata_o;
    logic        stall_o;
`ifdef DMEM_CTRL_PERF_EN
    logic [31:0] stall_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    dmem_access_ctrl #(.AW(32), .DW(32)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .M_i         (M_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o)
`ifdef DMEM_CTRL_PERF_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          req_rises = 0;
    logic        req_prev = 1'b0;
    logic [31:0] last_rdata = 32'h0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (mem_req_o && !req_prev) req_rises <= req_rises + 1;
        req_prev <= mem_req_o;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One access: IDLE issue cycle, (waits+1) ACCESS cycles, then DONE.
    task automatic access(input logic [1:0] m, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits,
                          output int start_cyc, output int end_cyc);
        exp_t e;
        int   stalls;
        stalls  = 0;
        e.we    = m[0];
        e.addr  = a;
        e.wdata = wd;
        e.rdata = m[0] ? last_rdata : rd;
        if (!m[0]) last_rdata = rd;

        @(negedge clk_i);
        M_i = m; addr_i = a; wdata_i = wd; mem_ack_i = 1'b0;
        sb.push_back(e);
        start_cyc = cyc;
        #1;
        chk1("idle_req", mem_req_o, 1'b0);
        if (stall_o) stalls++;

        for (int i = 0; i <= waits; i++) begin
            @(negedge clk_i);
            addr_i      = ~a;
            wdata_i     = ~wd;
            mem_ack_i   = (i == waits);
            mem_rdata_i = (i == waits) ? rd : (32'hBAD0_0000 | 32'(i));
            #1;
            if (stall_o) stalls++;
            chk1("acc_req", mem_req_o, 1'b1);
            chk1("acc_we", mem_we_o, sb[0].we);
            chk32("acc_addr", mem_addr_o, sb[0].addr);
            chk32("acc_wdata", mem_wdata_o, sb[0].wdata);
        end

        @(negedge clk_i);
        mem_ack_i = 1'b0;
        end_cyc   = cyc;
        #1;
        e = sb.pop_front();
        chk1("done_stall", stall_o, 1'b0);
        chk1("done_req", mem_req_o, 1'b0);
        chk32("done_rdata", rdata_o, e.rdata);
        chk32("stall_cycles", 32'(stalls), 32'(2 + waits));
    endtask

    int s0, e0, s1, e1, r0;

    initial begin
        rst_n_i     = 1'b0;
        M_i         = 2'b00;
        addr_i      = 32'h0;
        wdata_i     = 32'h0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        #1;
        chk1("rst_req", mem_req_o, 1'b0);
        chk1("rst_we", mem_we_o, 1'b0);
        chk32("rst_addr", mem_addr_o, 32'h0);
        chk32("rst_wdata", mem_wdata_o, 32'h0);
        chk32("rst_rdata", rdata_o, 32'h0);
        chk1("rst_stall", stall_o, 1'b0);
        M_i = 2'b10;
        #1;
        chk1("rst_stall_comb", stall_o, 1'b1);
        M_i = 2'b00;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Zero-wait load.
        r0 = req_rises;
        access(2'b10, 32'h40, 32'h0, 32'hDEADBEEF, 0, s0, e0);
        @(negedge clk_i);
        M_i = 2'b00;
        #1;
        chk1("no_reissue_ld", mem_req_o, 1'b0);
        chk32("ld_req_count", 32'(req_rises - r0), 32'd1);

        // Store with three wait cycles; ack data must not reach rdata_o.
        access(2'b01, 32'h80, 32'h12345678, 32'hCAFEF00D, 3, s0, e0);
        @(negedge clk_i);
        M_i = 2'b00;
        #1;
        chk1("no_reissue_st", mem_req_o, 1'b0);
`ifdef DMEM_CTRL_PERF_EN
        chk32("perf_cnt_7", stall_cnt_o, 32'd7);
`endif

        // Back-to-back load then store.
        r0 = req_rises;
        access(2'b10, 32'h100, 32'h0, 32'hA5A5_0001, 0, s0, e0);
        access(2'b01, 32'h104, 32'h0BAD_F00D, 32'h7777_7777, 0, s1, e1);
        chk32("b2b_accept", 32'(s1), 32'(e0 + 1));
        chk32("b2b_cycles", 32'(e1 - s0 + 1), 32'd6);
        @(negedge clk_i);
        M_i = 2'b00;
        #1;
        chk1("no_reissue_b2b", mem_req_o, 1'b0);
        chk32("b2b_req_count", 32'(req_rises - r0), 32'd2);

        // Spurious ack while idle.
        @(negedge clk_i);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFFFF_0000;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        chk1("spur_req", mem_req_o, 1'b0);
        chk1("spur_stall", stall_o, 1'b0);
        chk32("spur_rdata", rdata_o, last_rdata);

        // Illegal M=11 is issued as a write.
        access(2'b11, 32'h200, 32'h5A5A_5A5A, 32'h1111_2222, 1, s0, e0);
        @(negedge clk_i);
        M_i = 2'b00;

        // Reset asserted during ACCESS.
        @(negedge clk_i);
        M_i    = 2'b10;
        addr_i = 32'h300;
        @(negedge clk_i);
        #1;
        chk1("mid_req_before", mem_req_o, 1'b1);
        #2;
        rst_n_i = 1'b0;
        M_i     = 2'b00;
        #1;
        chk1("mid_rst_req", mem_req_o, 1'b0);
        chk1("mid_rst_we", mem_we_o, 1'b0);
        chk32("mid_rst_addr", mem_addr_o, 32'h0);
        chk32("mid_rst_wdata", mem_wdata_o, 32'h0);
        chk32("mid_rst_rdata", rdata_o, 32'h0);
        chk1("mid_rst_stall", stall_o, 1'b0);
        last_rdata = 32'h0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h5555_5555;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        chk1("late_ack_req", mem_req_o, 1'b0);
        chk1("late_ack_stall", stall_o, 1'b0);
        chk32("late_ack_rdata", rdata_o, 32'h0);
`ifdef DMEM_CTRL_PERF_EN
        chk32("perf_cnt_rst", stall_cnt_o, 32'd0);

        // Counter near saturation: five stall cycles must pin it at all-ones.
        @(negedge clk_i);
        force dut.u_perf_cnt.cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.u_perf_cnt.cnt_q;
        access(2'b10, 32'h400, 32'h0, 32'h0123_4567, 3, s0, e0);
        @(negedge clk_i);
        M_i = 2'b00;
        #1;
        chk32("perf_sat", stall_cnt_o, 32'hFFFF_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
